// File: rtl/mux_share_pkg.sv
// Shared types and helpers for the mux-share round-robin arbiter.
package mux_share_pkg;

    // Arbiter ownership state.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Smallest legal index width (a 1-requester index still needs one bit).
    localparam int MIN_IDX_W = 1;

    // Width of a binary requester index for n requesters.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : MIN_IDX_W;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after i_last, with wrap-around.
// N is a power of two, so index arithmetic wraps naturally at IW bits.
module rr_pick
    import mux_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    // Candidate k is i_last+k+1; the final candidate wraps onto i_last itself,
    // so the previous owner is still eligible when nobody else is requesting.
    logic [IW-1:0] w_cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign w_cand[gi] = i_last + IW'(gi + 1);
        end
    endgenerate

    // Priority encode over the rotated order; the lowest offset wins by being written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[w_cand[i]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[i];
            end
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning a shared W-bit N:1 datapath mux.
// Grant/select are registered; the data mux follows din combinationally.
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         dout,
    output logic                 dout_valid,
    output logic                 busy
);

    localparam int IW = idx_width(N);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    r_state, w_state_next;
    logic [N-1:0]  r_gnt,   w_gnt_next;
    logic [IW-1:0] r_sel,   w_sel_next;
    logic [IW-1:0] r_last,  w_last_next;
    logic [HW-1:0] r_hold,  w_hold_next;

    logic          w_release;
    logic          w_found;
    logic [IW-1:0] w_pick_last;
    logic [IW-1:0] w_pick_idx;
    logic [N-1:0]  w_pick_onehot;
    logic [W-1:0]  w_din_arr [N];

    // In IDLE the search starts after the last released owner; while OWNED the
    // pick is only consumed on a release edge, where the new last is the owner.
    assign w_pick_last   = (r_state == OWNED) ? r_sel : r_last;
    assign w_pick_onehot = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_release     = !req[r_sel] || (r_hold == HOLD_LAST);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (w_pick_last),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // Unpack the requester data bus for the shared output mux.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_din
            assign w_din_arr[gi] = din[gi*W +: W];
        end
    endgenerate

    // State register: ownership, grant, select, round-robin pointer and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= IW'(N - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_last  <= w_last_next;
            r_hold  <= w_hold_next;
        end
    end

    // Next-state: grant from IDLE, hold or hand over (back-to-back) while OWNED.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_last_next  = r_last;
        w_hold_next  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = OWNED;
                    w_gnt_next   = w_pick_onehot;
                    w_sel_next   = w_pick_idx;
                    w_hold_next  = '0;
                end
            end
            OWNED: begin
                if (!w_release) begin
                    w_hold_next = r_hold + 1'b1;
                end else begin
                    w_last_next = r_sel;
                    if (w_found) begin
                        w_gnt_next  = w_pick_onehot;
                        w_sel_next  = w_pick_idx;
                        w_hold_next = '0;
                    end else begin
                        w_state_next = IDLE;
                        w_gnt_next   = '0;
                        w_hold_next  = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs: registered grant/select, and the shared mux gated by grant validity.
    always_comb begin
        gnt        = r_gnt;
        sel        = r_sel;
        busy       = (r_state == OWNED);
        dout_valid = |r_gnt;
        dout       = dout_valid ? w_din_arr[r_sel] : '0;
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter (N=4, W=8, MAX_HOLD=4).
module tb_mux_share_arbiter;

    localparam logic [31:0] DIN_A = {8'hB3, 8'hC2, 8'hA1, 8'h50};
    localparam logic [31:0] DIN_B = {8'h5E, 8'hC2, 8'hA1, 8'h50};

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] dout;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    mux_share_arbiter #(
        .N        (4),
        .W        (8),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s txn=%0d: got %0h want %0h", name, txn, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and push what the DUT must show after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                        input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        din   = d;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = (eg != 4'b0);
        e.busy  = (eg != 4'b0);
        e.dout  = (eg != 4'b0) ? d[es*8 +: 8] : 8'h00;
        sb_q.push_back(e);
    endtask

    // Monitor: after every edge, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn %0d: req=%b gnt=%b sel=%0d dout=%h valid=%b busy=%b (exp gnt=%b sel=%0d dout=%h)",
                         txn, req, gnt, sel, dout, dout_valid, busy, e.gnt, e.sel, e.dout);
                chk("gnt",        32'(gnt),        32'(e.gnt));
                chk("sel",        32'(sel),        32'(e.sel));
                chk("dout",       32'(dout),       32'(e.dout));
                chk("dout_valid", 32'(dout_valid), 32'(e.valid));
                chk("busy",       32'(busy),       32'(e.busy));
                txn++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0;
        din   = DIN_A;

        // Reset, then idle with no requests.
        step(1'b1, 4'b0000, DIN_A, 4'b0000, 2'd0);
        step(1'b1, 4'b0000, DIN_A, 4'b0000, 2'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, DIN_A, 4'b0000, 2'd0);

        // Requesters 1 and 3 alternate, MAX_HOLD cycles each, no gap.
        for (int k = 0; k < 4; k++) step(1'b0, 4'b1010, DIN_A, 4'b0010, 2'd1);
        for (int k = 0; k < 4; k++) step(1'b0, 4'b1010, DIN_A, 4'b1000, 2'd3);
        step(1'b0, 4'b1010, DIN_A, 4'b0010, 2'd1);
        // Owner drops, nobody else: back to IDLE, sel holds.
        step(1'b0, 4'b0000, DIN_A, 4'b0000, 2'd1);

        // Fresh reset, then all requesting: owners 0,1,2,3,0 for 4 cycles each.
        step(1'b1, 4'b1111, DIN_A, 4'b0000, 2'd0);
        for (int k = 0; k < 20; k++) begin
            int o;
            o = (k / 4) % 4;
            step(1'b0, 4'b1111, DIN_A, 4'(1 << o), 2'(o));
        end
        // Handover to 1, then reset mid-grant with all requesting.
        step(1'b0, 4'b1111, DIN_A, 4'b0010, 2'd1);
        step(1'b0, 4'b1111, DIN_A, 4'b0010, 2'd1);
        step(1'b1, 4'b1111, DIN_A, 4'b0000, 2'd0);
        step(1'b0, 4'b1111, DIN_A, 4'b0001, 2'd0);
        step(1'b0, 4'b0000, DIN_A, 4'b0000, 2'd0);

        // Sole requester 2: forced release re-grants it with no valid drop.
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0100, DIN_A, 4'b0100, 2'd2);
        step(1'b0, 4'b0000, DIN_A, 4'b0000, 2'd2);

        // Owner 0 drops early while 3 rises: immediate handover to 3.
        step(1'b0, 4'b0001, DIN_A, 4'b0001, 2'd0);
        step(1'b0, 4'b0001, DIN_A, 4'b0001, 2'd0);
        step(1'b0, 4'b1000, DIN_A, 4'b1000, 2'd3);
        // Non-owner request ignored while owned; dout tracks new din.
        step(1'b0, 4'b1001, DIN_B, 4'b1000, 2'd3);
        step(1'b0, 4'b0000, DIN_A, 4'b0000, 2'd3);

        // Let the monitor drain the scoreboard within a bounded wait.
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
